// File: rtl/mips_define.sv
// Shared MIPS pipeline definitions: pc_src encodings, NOP word, default reset PC.
package mips_define;

  localparam logic [1:0]  PC_NEXT      = 2'b00;
  localparam logic [1:0]  PC_JUMP      = 2'b01;
  localparam logic [1:0]  PC_BRANCH    = 2'b10;

  localparam logic [31:0] INST_NOP     = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/if_hold_buffer.sv
// One-entry skid register that parks a fetched word while the IF/ID register is stalled.
module if_hold_buffer
  import mips_define::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              drain,
  input  logic              flush,
  input  logic [31:0]       word_in,
  input  logic [ADDR_W-1:0] addr_in,
  output logic [31:0]       word,
  output logic [ADDR_W-1:0] addr,
  output logic              full
);

  // Capture on load; drain and flush both empty the entry, contents are don't-care afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      word <= INST_NOP;
      addr <= '0;
    end else if (load) begin
      full <= 1'b1;
      word <= word_in;
      addr <= addr_in;
    end else if (drain || flush) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// MIPS IF stage: PC register, req/ack instruction-memory handshake and the IF/ID register.
module if_fetch_unit
  import mips_define::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_en,
  input  logic [1:0]        pc_src,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [ADDR_W-1:0] jump_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       inst_id,
  output logic [ADDR_W-1:0] pc_id,
  output logic [ADDR_W-1:0] pc_plus4_id,
  output logic              id_valid,
  output logic              fetch_stall
);

  localparam logic [0:0] S_FETCH = 1'b0;
  localparam logic [0:0] S_HOLD  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              req_q, req_d;
  logic              discard_q, discard_d;
  logic [31:0]       inst_q, inst_d;
  logic [ADDR_W-1:0] pc_id_q, pc_id_d;
  logic [ADDR_W-1:0] pc4_id_q, pc4_id_d;
  logic              valid_q, valid_d;

  logic              hold_load, hold_drain, hold_flush, hold_full;
  logic [31:0]       hold_word;
  logic [ADDR_W-1:0] hold_addr;

  logic              redirect;
  logic [ADDR_W-1:0] target_raw, target, pc_plus4, next_fetch;

  // ID-stage data is only trusted while the controller lets IF/ID advance.
  assign redirect   = if_en && ((pc_src == PC_JUMP) || (pc_src == PC_BRANCH));
  assign target_raw = (pc_src == PC_JUMP) ? jump_target : branch_target;
  assign target     = {target_raw[ADDR_W-1:2], 2'b00};
  assign pc_plus4   = pc_q + ADDR_W'(4);
  assign next_fetch = redirect ? target : pc_q;

  if_hold_buffer #(
    .ADDR_W (ADDR_W)
  ) u_hold (
    .clk     (clk),
    .rst     (rst),
    .load    (hold_load),
    .drain   (hold_drain),
    .flush   (hold_flush),
    .word_in (imem_rdata),
    .addr_in (addr_q),
    .word    (hold_word),
    .addr    (hold_addr),
    .full    (hold_full)
  );

  // Next-state logic for PC, fetch handshake and IF/ID register.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    req_d      = req_q;
    discard_d  = discard_q;
    inst_d     = inst_q;
    pc_id_d    = pc_id_q;
    pc4_id_d   = pc4_id_q;
    valid_d    = valid_q;
    hold_load  = 1'b0;
    hold_drain = 1'b0;
    hold_flush = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (!req_q) begin
          // First request after reset.
          req_d  = 1'b1;
          pc_d   = next_fetch;
          addr_d = next_fetch;
          if (if_en) begin
            valid_d = 1'b0;
            inst_d  = INST_NOP;
          end
        end else if (!imem_ack) begin
          if (if_en) begin
            valid_d = 1'b0;
            inst_d  = INST_NOP;
          end
          // The in-flight address stays put; its word is thrown away on arrival.
          if (redirect) begin
            pc_d      = target;
            discard_d = 1'b1;
          end
        end else if (discard_q) begin
          discard_d = 1'b0;
          pc_d      = next_fetch;
          addr_d    = next_fetch;
          if (if_en) begin
            valid_d = 1'b0;
            inst_d  = INST_NOP;
          end
        end else if (if_en) begin
          if (redirect) begin
            valid_d = 1'b0;
            inst_d  = INST_NOP;
            pc_d    = target;
            addr_d  = target;
          end else begin
            inst_d   = imem_rdata;
            pc_id_d  = addr_q;
            pc4_id_d = addr_q + ADDR_W'(4);
            valid_d  = 1'b1;
            pc_d     = pc_plus4;
            addr_d   = pc_plus4;
          end
        end else begin
          hold_load = 1'b1;
          state_d   = S_HOLD;
          req_d     = 1'b0;
        end
      end
      S_HOLD: begin
        if (if_en) begin
          state_d = S_FETCH;
          req_d   = 1'b1;
          if (redirect) begin
            hold_flush = 1'b1;
            valid_d    = 1'b0;
            inst_d     = INST_NOP;
            pc_d       = target;
            addr_d     = target;
          end else begin
            hold_drain = 1'b1;
            valid_d    = hold_full;
            inst_d     = hold_full ? hold_word : INST_NOP;
            pc_id_d    = hold_addr;
            pc4_id_d   = hold_addr + ADDR_W'(4);
            pc_d       = pc_plus4;
            addr_d     = pc_plus4;
          end
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // State registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      addr_q    <= RESET_PC;
      req_q     <= 1'b0;
      discard_q <= 1'b0;
      inst_q    <= INST_NOP;
      pc_id_q   <= '0;
      pc4_id_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      req_q     <= req_d;
      discard_q <= discard_d;
      inst_q    <= inst_d;
      pc_id_q   <= pc_id_d;
      pc4_id_q  <= pc4_id_d;
      valid_q   <= valid_d;
    end
  end

  // Output mapping; the stall flag reflects the live ack.
  always_comb begin
    imem_req    = req_q;
    imem_addr   = addr_q;
    inst_id     = inst_q;
    pc_id       = pc_id_q;
    pc_plus4_id = pc4_id_q;
    id_valid    = valid_q;
    fetch_stall = (state_q == S_FETCH) && req_q && (!imem_ack || discard_q);
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: per-cycle vector table plus reset and wrap sequences.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_en;
  logic [1:0]  pc_src;
  logic [31:0] branch_target, jump_target;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] inst_id, pc_id, pc_plus4_id;
  logic        id_valid, fetch_stall;

  // Second instance exercising the wrap-around reset PC.
  logic        rst2;
  logic        req2, ack2, valid2, stall2;
  logic [31:0] addr2, rdata2, inst2, pc_id2, pc4_2;

  int lat;
  int wait_cnt;
  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory model: acks once a request has been pending for lat cycles (lat=1 is zero-wait).
  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) wait_cnt <= 0;
    else                              wait_cnt <= wait_cnt + 1;
  end
  always_comb begin
    imem_ack   = !rst && imem_req && (wait_cnt >= lat - 1);
    imem_rdata = mem_word(imem_addr);
    ack2       = !rst2 && req2;
    rdata2     = mem_word(addr2);
  end

  if_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .if_en         (if_en),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .inst_id       (inst_id),
    .pc_id         (pc_id),
    .pc_plus4_id   (pc_plus4_id),
    .id_valid      (id_valid),
    .fetch_stall   (fetch_stall)
  );

  if_fetch_unit #(
    .ADDR_W   (32),
    .RESET_PC (32'hFFFF_FFFC)
  ) dut_wrap (
    .clk           (clk),
    .rst           (rst2),
    .if_en         (1'b1),
    .pc_src        (2'b00),
    .branch_target (32'h0000_0300),
    .jump_target   (32'h0000_0500),
    .imem_req      (req2),
    .imem_addr     (addr2),
    .imem_ack      (ack2),
    .imem_rdata    (rdata2),
    .inst_id       (inst2),
    .pc_id         (pc_id2),
    .pc_plus4_id   (pc4_2),
    .id_valid      (valid2),
    .fetch_stall   (stall2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        if_en;
    logic [1:0]  pc_src;
    logic [31:0] btgt;
    logic [31:0] jtgt;
    int          lat;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc_id;
    logic        stall;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic en, input logic [1:0] src, input logic [31:0] bt,
                             input logic [31:0] jt, input int l, input logic rq,
                             input logic [31:0] ad, input logic vl, input logic [31:0] pid,
                             input logic st);
    vec_t r;
    r.if_en = en; r.pc_src = src; r.btgt = bt; r.jtgt = jt; r.lat = l;
    r.req = rq; r.addr = ad; r.valid = vl; r.pc_id = pid; r.stall = st;
    return r;
  endfunction

  localparam logic [31:0] B = 32'h0000_0300;
  localparam logic [31:0] J = 32'h0000_0500;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Row = one cycle: inputs held during the cycle, outputs expected in that cycle.
    tbl.push_back(v(1, 2'b00, B, J, 1, 0, 32'h00, 0, 32'h00, 0)); // c0  idle after reset
    tbl.push_back(v(1, 2'b00, B, J, 1, 1, 32'h00, 0, 32'h00, 0)); // c1  first request
    tbl.push_back(v(1, 2'b00, B, J, 1, 1, 32'h04, 1, 32'h00, 0)); // c2  zero-wait stream
    tbl.push_back(v(1, 2'b00, B, J, 1, 1, 32'h08, 1, 32'h04, 0));
    tbl.push_back(v(1, 2'b00, B, J, 1, 1, 32'h0C, 1, 32'h08, 0));
    tbl.push_back(v(1, 2'b00, B, J, 3, 1, 32'h10, 1, 32'h0C, 1)); // c5  3-cycle latency
    tbl.push_back(v(1, 2'b00, B, J, 3, 1, 32'h10, 0, 32'h00, 1));
    tbl.push_back(v(1, 2'b00, B, J, 3, 1, 32'h10, 0, 32'h00, 0)); // c7  ack
    tbl.push_back(v(0, 2'b00, B, J, 1, 1, 32'h14, 1, 32'h10, 0)); // c8  ack with if_en=0
    tbl.push_back(v(0, 2'b00, B, J, 1, 0, 32'h14, 1, 32'h10, 0)); // c9  holding
    tbl.push_back(v(1, 2'b00, B, J, 1, 0, 32'h14, 1, 32'h10, 0)); // c10 release
    tbl.push_back(v(1, 2'b10, 32'h40, J, 2, 1, 32'h18, 1, 32'h14, 1)); // c11 branch in flight
    tbl.push_back(v(1, 2'b00, B, J, 2, 1, 32'h18, 0, 32'h00, 1)); // c12 stale ack discarded
    tbl.push_back(v(1, 2'b00, B, J, 2, 1, 32'h40, 0, 32'h00, 1));
    tbl.push_back(v(1, 2'b00, B, J, 2, 1, 32'h40, 0, 32'h00, 0)); // c14 target word
    tbl.push_back(v(0, 2'b01, B, 32'h103, 1, 1, 32'h44, 1, 32'h40, 0)); // c15 jump ignored
    tbl.push_back(v(0, 2'b01, B, 32'h103, 1, 0, 32'h44, 1, 32'h40, 0));
    tbl.push_back(v(1, 2'b00, B, J, 1, 0, 32'h44, 1, 32'h40, 0)); // c17 drain
    tbl.push_back(v(1, 2'b01, B, 32'h103, 1, 1, 32'h48, 1, 32'h44, 0)); // c18 jump + ack
    tbl.push_back(v(1, 2'b00, B, J, 1, 1, 32'h100, 0, 32'h00, 0));
    tbl.push_back(v(1, 2'b11, 32'h200, 32'h200, 1, 1, 32'h104, 1, 32'h100, 0)); // c20 src=11
    tbl.push_back(v(1, 2'b00, B, J, 1, 1, 32'h108, 1, 32'h104, 0));

    rst = 1'b1; rst2 = 1'b1; if_en = 1'b1; pc_src = 2'b00;
    branch_target = B; jump_target = J; lat = 1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset imem_req", {31'd0, imem_req}, 32'd0);
    check("reset imem_addr", imem_addr, 32'h0);
    check("reset id_valid", {31'd0, id_valid}, 32'd0);
    check("reset inst_id", inst_id, 32'h0);
    check("reset pc_id", pc_id, 32'h0);
    check("reset pc_plus4_id", pc_plus4_id, 32'h0);
    check("reset fetch_stall", {31'd0, fetch_stall}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      if_en         = tbl[i].if_en;
      pc_src        = tbl[i].pc_src;
      branch_target = tbl[i].btgt;
      jump_target   = tbl[i].jtgt;
      lat           = tbl[i].lat;
      @(negedge clk);
      check($sformatf("c%0d imem_req", i), {31'd0, imem_req}, {31'd0, tbl[i].req});
      check($sformatf("c%0d imem_addr", i), imem_addr, tbl[i].addr);
      check($sformatf("c%0d id_valid", i), {31'd0, id_valid}, {31'd0, tbl[i].valid});
      check($sformatf("c%0d fetch_stall", i), {31'd0, fetch_stall}, {31'd0, tbl[i].stall});
      check($sformatf("c%0d inst_id", i), inst_id,
            tbl[i].valid ? mem_word(tbl[i].pc_id) : 32'h0);
      if (tbl[i].valid) begin
        check($sformatf("c%0d pc_id", i), pc_id, tbl[i].pc_id);
        check($sformatf("c%0d pc_plus4_id", i), pc_plus4_id, tbl[i].pc_id + 32'd4);
      end
      @(posedge clk);
      #1;
    end

    // Reset asserted while a slow request is outstanding.
    if_en = 1'b1; pc_src = 2'b00; lat = 3;
    @(negedge clk);
    check("midrst pending stall", {31'd0, fetch_stall}, 32'd1);
    check("midrst pending addr", imem_addr, 32'h10C);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst imem_req", {31'd0, imem_req}, 32'd0);
    check("midrst imem_addr", imem_addr, 32'h0);
    check("midrst id_valid", {31'd0, id_valid}, 32'd0);
    check("midrst inst_id", inst_id, 32'h0);
    check("midrst pc_id", pc_id, 32'h0);
    check("midrst pc_plus4_id", pc_plus4_id, 32'h0);
    check("midrst fetch_stall", {31'd0, fetch_stall}, 32'd0);

    // Wrap-around reset PC on the second instance.
    @(posedge clk);
    #1 rst2 = 1'b0;
    @(negedge clk);
    check("wrap c0 req", {31'd0, req2}, 32'd0);
    check("wrap c0 addr", addr2, 32'hFFFF_FFFC);
    @(posedge clk);
    @(negedge clk);
    check("wrap c1 req", {31'd0, req2}, 32'd1);
    check("wrap c1 addr", addr2, 32'hFFFF_FFFC);
    check("wrap c1 stall", {31'd0, stall2}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("wrap c2 addr", addr2, 32'h0);
    check("wrap c2 valid", {31'd0, valid2}, 32'd1);
    check("wrap c2 pc_id", pc_id2, 32'hFFFF_FFFC);
    check("wrap c2 pc_plus4_id", pc4_2, 32'h0);
    check("wrap c2 inst", inst2, mem_word(32'hFFFF_FFFC));
    @(posedge clk);
    @(negedge clk);
    check("wrap c3 addr", addr2, 32'h4);
    check("wrap c3 pc_id", pc_id2, 32'h0);
    check("wrap c3 pc_plus4_id", pc4_2, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
